md_ctrl: RTL and testbench
==========================

# md_ctrl

Multiply/divide sequencer for the pipelined MIPS core, sitting beside the ALU in the E stage. It accepts mult/multu/div/divu and mthi/mtlo from E, holds the HI/LO registers, and models the fixed multi-cycle latency with a busy counter. It drives the D-stage stall request while the unit is occupied. HI/LO read data feeds the M-stage write-data selection for mfhi/mflo.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  core clock, rising edge
- reset_n  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low
- start  in  1  E-stage instruction is a valid MD op this cycle
- md_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 reserved
- a  in  32  E-stage forwarded rs value
- b  in  32  E-stage forwarded rt value
- d_md_use  in  1  D-stage instruction uses the MD unit (mult*/div*/mthi/mtlo/mfhi/mflo)
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in progress
- stall_req  out  1  freeze PC/F-D, bubble D-E

## Operation
- States: IDLE, BUSY. The state is held in a counter `cnt`. `cnt==0` means IDLE.
- IDLE, start with md_op 0–3:
  - Latch the result into hi_n/lo_n. The product or the remainder/quotient is computed from a and b on this edge.
  - Load cnt = MULT_CYCLES or DIV_CYCLES.
- IDLE, start with md_op 4: hi ← a next edge, no busy. md_op 5: lo ← a likewise.
- IDLE, start with md_op 6–7: ignored, no state change.
- BUSY: cnt decrements each edge. On the edge where cnt==1:
  - hi ← hi_n, lo ← lo_n.
  - cnt → 0, which returns the unit to IDLE.
- start while BUSY: ignored. This cannot occur when stall_req is honoured, and a bench assertion flags it.
- busy = (cnt != 0), registered.
- stall_req = d_md_use & (busy | (start & md_op<=3)). Combinational.
- Arithmetic:
  - mult: 64-bit signed product. multu: unsigned product. {hi,lo} = product.
  - div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend. divu: unsigned quotient and remainder.
  - b==0: hi_n/lo_n = current hi/lo, so HI/LO are unchanged. Full DIV_CYCLES latency is still incurred.
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- hi/lo hold their old values throughout BUSY. mfhi/mflo issued during BUSY are stalled by d_md_use.

## Timing
- Reset (reset_n low at an edge): cnt=0, hi=0, lo=0, hi_n=0, lo_n=0, busy=0. stall_req then depends only on inputs and reduces to d_md_use & start & md_op<=3.
- Reset asserted mid-operation: abort at that edge. No HI/LO writeback, all state returns to reset values.
- Latency: start at edge t, busy high for cycles t+1 … t+N. New HI/LO are visible from cycle t+N+1, the same cycle busy falls. N is MULT_CYCLES or DIV_CYCLES.
- mthi/mtlo: value visible the cycle after start, zero busy cycles.
- Back-to-back: a new start is accepted in the first cycle with busy=0.

## Structure
- Shared package md_pkg holds:
  - md_op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - Default MULT_CYCLES and DIV_CYCLES constants.
  - The same encodings as used by the decoder in the D stage.
- One sub-module, md_arith: combinational 64-bit result generator. Inputs are md_op, a, b, hi, lo. Outputs are hi_n and lo_n, including the div-by-zero and overflow rules. md_ctrl contains only the counter, the registers and the stall logic.

## Test plan
- Reset, then mult a=0xFFFFFFFE (−2), b=3 → busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=2 → after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE. With d_md_use=1 throughout, stall_req is high on the start cycle and all 5 busy cycles, low afterward.
- div a=0xFFFFFFF9 (−7), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=7, b=2 → lo=3, hi=1.
- Preload hi=0x11, lo=0x22 via mthi/mtlo (each visible the next cycle, busy never rises). Then div by b=0 → 10 busy cycles, after which hi=0x11, lo=0x22.
- div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Start mult 6×7; drop reset_n at busy cycle 3 → next cycle busy=0, hi=lo=0. Then mult 6×7 completes normally with lo=42.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the md_op encodings (shared with the D-stage decoder), the default
// latencies, and a helper that classifies multi-cycle operations.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    // mult/multu/div/divu occupy the unit for several cycles; mthi/mtlo do not
    function automatic logic md_is_long(input logic [2:0] op);
        return (op <= 3'd3);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result generator for the multiply/divide unit.
// Ports:
//   md_op      operation code (see md_pkg)
//   a, b       forwarded rs / rt operands
//   hi, lo     current HI/LO contents (returned unchanged on divide by zero)
//   hi_n, lo_n result to be written to HI/LO when the operation retires
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_mag_safe;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_u;
    logic [31:0] r_u;

    // Low 64 bits of the product of sign-extended operands equal the signed product
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes. 0x80000000 / -1 falls out naturally:
    // |a| = 0x80000000, quotient negated wraps back to 0x80000000, remainder 0.
    assign a_mag      = a[31] ? (~a + 32'd1) : a;
    assign b_mag      = b[31] ? (~b + 32'd1) : b;
    assign b_mag_safe = (b_mag == '0) ? 32'd1 : b_mag;
    assign b_safe     = (b == '0) ? 32'd1 : b;
    assign q_mag      = a_mag / b_mag_safe;
    assign r_mag      = a_mag % b_mag_safe;
    assign q_u        = a / b_safe;
    assign r_u        = a % b_safe;

    always_comb begin
        hi_n = hi;
        lo_n = lo;
        case (md_op)
            MD_MULT:  {hi_n, lo_n} = prod_s;
            MD_MULTU: {hi_n, lo_n} = prod_u;
            MD_DIV: begin
                if (b != '0) begin
                    lo_n = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
                    hi_n = a[31] ? (~r_mag + 32'd1) : r_mag;
                end
            end
            MD_DIVU: begin
                if (b != '0) begin
                    lo_n = q_u;
                    hi_n = r_u;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for the E stage.
// Accepts mult/multu/div/divu/mthi/mtlo, holds HI/LO, models the fixed
// latency with a down-counter (cnt == 0 is idle) and requests D-stage stalls.
// Ports:
//   clk        core clock, rising edge
//   reset_n    synchronous active-low reset
//   start      E-stage instruction is a valid MD op
//   md_op      operation code (md_pkg encodings, 6-7 reserved)
//   a, b       forwarded rs / rt values
//   d_md_use   D-stage instruction uses the MD unit
//   hi, lo     HI/LO registers
//   busy       operation in progress (registered)
//   stall_req  freeze PC/F-D and bubble D-E (combinational)
module md_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_md_use,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_req
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      hi_d;
    logic [31:0]      lo_d;
    logic [31:0]      hi_n_q;
    logic [31:0]      lo_n_q;
    logic [31:0]      hi_n_d;
    logic [31:0]      lo_n_d;
    logic [31:0]      arith_hi;
    logic [31:0]      arith_lo;

    md_arith u_arith (
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .hi_n  (arith_hi),
        .lo_n  (arith_lo)
    );

    always_comb begin
        cnt_d  = cnt;
        hi_d   = hi;
        lo_d   = lo;
        hi_n_d = hi_n_q;
        lo_n_d = lo_n_q;
        if (cnt == '0) begin
            if (start) begin
                case (md_op)
                    MD_MULT, MD_MULTU: begin
                        hi_n_d = arith_hi;
                        lo_n_d = arith_lo;
                        cnt_d  = CNT_W'(MULT_CYCLES);
                    end
                    MD_DIV, MD_DIVU: begin
                        hi_n_d = arith_hi;
                        lo_n_d = arith_lo;
                        cnt_d  = CNT_W'(DIV_CYCLES);
                    end
                    MD_MTHI: hi_d = a;
                    MD_MTLO: lo_d = a;
                    default: ;
                endcase
            end
        end else begin
            // start is ignored here; the stall keeps new MD ops out of E
            cnt_d = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                hi_d = hi_n_q;
                lo_d = lo_n_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            hi_n_q <= '0;
            lo_n_q <= '0;
            busy   <= 1'b0;
        end else begin
            cnt    <= cnt_d;
            hi     <= hi_d;
            lo     <= lo_d;
            hi_n_q <= hi_n_d;
            lo_n_q <= lo_n_d;
            // registered from the next count so busy always equals (cnt != 0)
            busy   <= (cnt_d != '0);
        end
    end

    assign stall_req = d_md_use & (busy | (start & md_is_long(md_op)));

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed vector table, mid-operation reset
// sequence, and randomized operations checked against a reference model.
module tb_md_ctrl;
    import md_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        d_md_use = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_req;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] av;
        logic [31:0] bv;
        logic        use_d;
        logic [31:0] eh;
        logic [31:0] el;
        int          en;
    } vec_t;

    vec_t tbl [11];

    md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .md_op     (md_op),
        .a         (a),
        .b         (b),
        .d_md_use  (d_md_use),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n && start && busy)
            $error("start issued while unit busy");
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Reference: architectural MIPS HI/LO semantics with 64-bit integer arithmetic
    task automatic ref_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] rh, output logic [31:0] rl, output int n);
        longint          sa;
        longint          sb;
        longint          sp;
        longint unsigned up;
        rh = m_hi;
        rl = m_lo;
        n  = 0;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (op)
            3'd0: begin sp = sa * sb; {rh, rl} = sp; n = MC; end
            3'd1: begin up = longint'(av) * longint'(bv); {rh, rl} = up; n = MC; end
            3'd2: begin
                n = DC;
                if (bv != 0) begin rl = 32'(sa / sb); rh = 32'(sa % sb); end
            end
            3'd3: begin
                n = DC;
                if (bv != 0) begin rl = av / bv; rh = av % bv; end
            end
            3'd4: rh = av;
            3'd5: rl = av;
            default: ;
        endcase
    endtask

    // Called at a negedge with the unit idle; returns at the negedge of the
    // first idle cycle so consecutive calls issue back-to-back.
    task automatic do_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic use_d, input logic [31:0] eh, input logic [31:0] el,
                         input int en, input string tag);
        int cyc;
        start = 1'b1; md_op = op; a = av; b = bv; d_md_use = use_d;
        #1;
        chk({tag, " stall_start"}, 64'(stall_req), 64'(use_d & (op <= 3'd3)));
        @(negedge clk);
        start = 1'b0; md_op = 3'($urandom); a = $urandom; b = $urandom;
        cyc = 0;
        while (busy && cyc < 100) begin
            chk({tag, " stall_busy"}, 64'(stall_req), 64'(use_d));
            chk({tag, " hold_hilo"}, {hi, lo}, {m_hi, m_lo});
            cyc++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, 64'(cyc), 64'(en));
        chk({tag, " hi"}, 64'(hi), 64'(eh));
        chk({tag, " lo"}, 64'(lo), 64'(el));
        chk({tag, " stall_done"}, 64'(stall_req), 64'(0));
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] eh;
        logic [31:0] el;
        logic        ud;
        int          en;
        int          r;

        tbl[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        1'b1, 32'h00000001, 32'hFFFFFFFE, MC};
        tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        tbl[3]  = '{3'd3, 32'd7,        32'd2,        1'b1, 32'd1,        32'd3,        DC};
        tbl[4]  = '{3'd4, 32'h11,       32'd0,        1'b1, 32'h11,       32'd3,        0};
        tbl[5]  = '{3'd5, 32'h22,       32'd0,        1'b1, 32'h11,       32'h22,       0};
        tbl[6]  = '{3'd2, 32'd5,        32'd0,        1'b1, 32'h11,       32'h22,       DC};
        tbl[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h80000000, DC};
        tbl[8]  = '{3'd6, 32'h123,      32'd4,        1'b1, 32'h0,        32'h80000000, 0};
        tbl[9]  = '{3'd7, 32'h456,      32'd4,        1'b0, 32'h0,        32'h80000000, 0};
        tbl[10] = '{3'd3, 32'd9,        32'd0,        1'b1, 32'h0,        32'h80000000, DC};

        // reset state and reset-time stall behaviour
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst hi", 64'(hi), 64'(0));
        chk("rst lo", 64'(lo), 64'(0));
        start = 1'b1; md_op = 3'd0; d_md_use = 1'b1;
        #1;
        chk("rst stall_mult", 64'(stall_req), 64'(1));
        md_op = 3'd4;
        #1;
        chk("rst stall_mthi", 64'(stall_req), 64'(0));
        start = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++)
            do_op(tbl[i].op, tbl[i].av, tbl[i].bv, tbl[i].use_d, tbl[i].eh, tbl[i].el,
                  tbl[i].en, $sformatf("vec%0d", i));

        // mid-operation reset: preload, start mult, reset at third busy cycle
        do_op(3'd4, 32'h55, 32'd0, 1'b0, 32'h55, 32'h80000000, 0, "pre_hi");
        do_op(3'd5, 32'h66, 32'd0, 1'b0, 32'h55, 32'h66, 0, "pre_lo");
        start = 1'b1; md_op = 3'd0; a = 32'd6; b = 32'd7; d_md_use = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort busy_before", 64'(busy), 64'(1));
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort hi", 64'(hi), 64'(0));
        chk("abort lo", 64'(lo), 64'(0));
        chk("abort stall", 64'(stall_req), 64'(0));
        reset_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        do_op(3'd0, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, MC, "after_abort");

        // randomized operations against the reference model
        for (int i = 0; i < 80; i++) begin
            r  = $urandom_range(0, 9);
            op = (r < 8) ? 3'(r) : 3'($urandom_range(4, 5));
            av = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : 32'($urandom);
            case ($urandom_range(0, 5))
                0: bv = '0;
                1: bv = 32'hFFFFFFFF;
                2: bv = 32'($urandom_range(1, 9));
                default: bv = 32'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) begin av = 32'h80000000; bv = 32'hFFFFFFFF; end
            ud = 1'($urandom);
            ref_op(op, av, bv, eh, el, en);
            do_op(op, av, bv, ud, eh, el, en, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
